// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table pipeline: task descriptor passed between
// stages, head RAM entry format and the head RAM write-port bundle.
package hash_table;

    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 10;
    localparam int KEY_WIDTH      = 32;
    localparam int VALUE_WIDTH    = 32;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NOP    = 2'd3
    } ht_cmd_t;

    // One head RAM entry: pointer to the first data-table entry of a bucket
    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        ht_cmd_t                   cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_data_task_t;

    // Head RAM write port, driven by the data table or the clear sweep
    typedef struct packed {
        logic [BUCKET_WIDTH-1:0] addr;
        head_ram_data_t          data;
        logic                    en;
    } head_ram_wr_t;

    typedef enum logic {
        HTL_INIT = 1'b0,
        HTL_RUN  = 1'b1
    } htl_state_t;

    // Return a copy of a task with its head fields replaced
    function automatic ht_data_task_t with_head(input ht_data_task_t t,
                                                input head_ram_data_t h);
        ht_data_task_t r;
        r              = t;
        r.head_ptr     = h.ptr;
        r.head_ptr_val = h.ptr_val;
        return r;
    endfunction

endpackage

// File: rtl/head_table_lookup_head_ram.sv
// Simple dual-port head RAM, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old data.
module head_ram
    import hash_table::*;
(
    input  logic                    clk,
    input  head_ram_wr_t            wr_port,
    input  logic                    rd_en,
    input  logic [BUCKET_WIDTH-1:0] rd_addr,
    output head_ram_data_t          rd_data
);

    localparam int DEPTH = 2 ** BUCKET_WIDTH;

    head_ram_data_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_port.en) begin
            mem[wr_port.addr] <= wr_port.data;
        end
    end

    // Registered read port; sees the array before this cycle's write
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/head_table_lookup.sv
// Head table lookup: resolves the bucket head pointer for each hashed task
// through a two-stage pipeline in front of the data-table walker. Owns the
// head RAM, applies head updates from the data table with forwarding into
// in-flight tasks, and sweep-clears the RAM after reset.
// Optional build macro HEAD_TABLE_LOOKUP_STATS_EN adds saturating lookup
// and empty-head counters as output ports.
module head_table_lookup
    import hash_table::ht_data_task_t;
    import hash_table::head_ram_data_t;
    import hash_table::head_ram_wr_t;
    import hash_table::htl_state_t;
    import hash_table::HTL_INIT;
    import hash_table::HTL_RUN;
    import hash_table::with_head;
#(
    // Field widths of the task struct come from the package; these must match it
    parameter int BUCKET_WIDTH   = hash_table::BUCKET_WIDTH,
    parameter int HEAD_PTR_WIDTH = hash_table::HEAD_PTR_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ht_data_task_t           task_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,
    output ht_data_task_t           task_o,
    output logic                    task_valid_o,
    input  logic                    task_ready_i,
    input  logic                    head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] head_wr_addr_i,
    input  logic [HEAD_PTR_WIDTH:0] head_wr_data_i,
    output logic                    init_done_o
`ifdef HEAD_TABLE_LOOKUP_STATS_EN
    ,
    output logic [31:0]             stat_lookups_o,
    output logic [31:0]             stat_empty_head_o
`endif
);

    localparam logic [BUCKET_WIDTH-1:0] CLR_LAST = '1;

    htl_state_t              state_reg;
    htl_state_t              state_next;
    logic [BUCKET_WIDTH-1:0] clr_cnt_reg;

    head_ram_wr_t            ram_wr;
    head_ram_data_t          ram_rd_data;
    head_ram_data_t          wr_data;
    logic                    wr_live;

    logic                    advance;
    logic                    accept;

    logic                    s1_valid_reg;
    logic                    s1_fresh_reg;
    ht_data_task_t           s1_task_reg;
    head_ram_data_t          s1_head_reg;
    head_ram_data_t          s1_head_cur;
    head_ram_data_t          s1_head_fwd;

    logic                    s2_valid_reg;
    ht_data_task_t           s2_task_reg;

    assign wr_data = head_ram_data_t'(head_wr_data_i);
    // Data-table writes only take effect once the clear sweep is over
    assign wr_live = (state_reg == HTL_RUN) && head_wr_en_i;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= HTL_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: leave INIT after the last address is cleared
    always_comb begin
        state_next = state_reg;
        if ((state_reg == HTL_INIT) && (clr_cnt_reg == CLR_LAST)) begin
            state_next = HTL_RUN;
        end
    end

    // FSM outputs: RAM write source and init status
    always_comb begin
        init_done_o = 1'b0;
        ram_wr      = '0;
        if (state_reg == HTL_INIT) begin
            ram_wr.en   = 1'b1;
            ram_wr.addr = clr_cnt_reg;
            ram_wr.data = '0;
        end else begin
            init_done_o = 1'b1;
            ram_wr.en   = head_wr_en_i;
            ram_wr.addr = head_wr_addr_i;
            ram_wr.data = wr_data;
        end
    end

    // Clear-sweep address counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_cnt_reg <= '0;
        end else if (state_reg == HTL_INIT) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
    end

    head_ram u_head_ram (
        .clk     (clk_i),
        .wr_port (ram_wr),
        .rd_en   (accept),
        .rd_addr (task_i.bucket),
        .rd_data (ram_rd_data)
    );

    assign advance      = !s2_valid_reg || task_ready_i;
    assign task_ready_o = (state_reg == HTL_RUN) && (!s1_valid_reg || advance);
    assign accept       = task_valid_i && task_ready_o;

    // S1 head: RAM output on the cycle after the read, own copy afterwards,
    // with a write to the same bucket this cycle taking precedence
    always_comb begin
        s1_head_cur = s1_fresh_reg ? ram_rd_data : s1_head_reg;
        s1_head_fwd = s1_head_cur;
        if (wr_live && (head_wr_addr_i == s1_task_reg.bucket)) begin
            s1_head_fwd = wr_data;
        end
    end

    // S1: accepted task waiting for its RAM read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_fresh_reg <= 1'b0;
            s1_task_reg  <= '0;
            s1_head_reg  <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_task_reg  <= task_i;
            // RAM returns old data on a same-cycle write, so take the write
            if (wr_live && (head_wr_addr_i == task_i.bucket)) begin
                s1_head_reg  <= wr_data;
                s1_fresh_reg <= 1'b0;
            end else begin
                s1_fresh_reg <= 1'b1;
            end
        end else if (advance) begin
            s1_valid_reg <= 1'b0;
            s1_fresh_reg <= 1'b0;
        end else if (s1_valid_reg) begin
            // Stalled: capture the head so the RAM read is never repeated
            s1_head_reg  <= s1_head_fwd;
            s1_fresh_reg <= 1'b0;
        end
    end

    // S2: output register, head kept current while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_reg <= 1'b0;
            s2_task_reg  <= '0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_task_reg  <= with_head(s1_task_reg, s1_head_fwd);
        end else if (s2_valid_reg && wr_live &&
                     (head_wr_addr_i == s2_task_reg.bucket)) begin
            s2_task_reg.head_ptr     <= wr_data.ptr;
            s2_task_reg.head_ptr_val <= wr_data.ptr_val;
        end
    end

    assign task_o       = s2_task_reg;
    assign task_valid_o = s2_valid_reg;

`ifdef HEAD_TABLE_LOOKUP_STATS_EN
    logic        out_fire;
    logic [31:0] stat_lookups_reg;
    logic [31:0] stat_empty_head_reg;

    assign out_fire = s2_valid_reg && task_ready_i;

    // Saturating counters of output handshakes and of empty-bucket results
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_lookups_reg    <= '0;
            stat_empty_head_reg <= '0;
        end else if (out_fire) begin
            if (stat_lookups_reg != 32'hFFFF_FFFF) begin
                stat_lookups_reg <= stat_lookups_reg + 32'd1;
            end
            if (!s2_task_reg.head_ptr_val && (stat_empty_head_reg != 32'hFFFF_FFFF)) begin
                stat_empty_head_reg <= stat_empty_head_reg + 32'd1;
            end
        end
    end

    assign stat_lookups_o    = stat_lookups_reg;
    assign stat_empty_head_o = stat_empty_head_reg;
`endif

endmodule

// File: tb/tb_head_table_lookup.sv
// Self-checking bench for head_table_lookup: directed steps plus a random
// stream, outputs checked against a scoreboard and a reference head table.
`timescale 1ns/1ps
module tb_head_table_lookup;
    import hash_table::*;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    ht_data_task_t  task_i;
    logic           task_valid_i = 1'b0;
    logic           task_ready_o;
    ht_data_task_t  task_o;
    logic           task_valid_o;
    logic           task_ready_i = 1'b1;
    logic           head_wr_en_i = 1'b0;
    logic [7:0]     head_wr_addr_i = 8'd0;
    head_ram_data_t head_wr_data_i = '0;
    logic           init_done_o;
`ifdef HEAD_TABLE_LOOKUP_STATS_EN
    logic [31:0]    stat_lookups_o;
    logic [31:0]    stat_empty_head_o;
`endif

    always #5 clk = ~clk;

    head_table_lookup dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .task_i         (task_i),
        .task_valid_i   (task_valid_i),
        .task_ready_o   (task_ready_o),
        .task_o         (task_o),
        .task_valid_o   (task_valid_o),
        .task_ready_i   (task_ready_i),
        .head_wr_en_i   (head_wr_en_i),
        .head_wr_addr_i (head_wr_addr_i),
        .head_wr_data_i (head_wr_data_i),
        .init_done_o    (init_done_o)
`ifdef HEAD_TABLE_LOOKUP_STATS_EN
        ,
        .stat_lookups_o    (stat_lookups_o),
        .stat_empty_head_o (stat_empty_head_o)
`endif
    );

    typedef struct {
        ht_data_task_t t;
        int            acc_cyc;
    } exp_t;

    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             n_out = 0;
    logic           lat_chk = 1'b1;
    exp_t           sb [$];
    head_ram_data_t ref_mem [256];
    ht_data_task_t  last_out = '0;
    ht_data_task_t  last_sent = '0;
    exp_t           e_m;
    ht_data_task_t  exp_m;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference head table: a write becomes visible from the next cycle on
    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) ref_mem[i] <= '0;
        end else if (head_wr_en_i) begin
            ref_mem[head_wr_addr_i] <= head_wr_data_i;
        end
    end

    // Scoreboard: compare each output handshake, record each accept
    always @(negedge clk) begin
        if (rst_i) begin
            sb.delete();
        end else begin
            if (task_valid_o && task_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {127'd0, task_valid_o}, 128'd0);
                end else begin
                    e_m = sb.pop_front();
                    exp_m = e_m.t;
                    exp_m.head_ptr     = ref_mem[e_m.t.bucket].ptr;
                    exp_m.head_ptr_val = ref_mem[e_m.t.bucket].ptr_val;
                    check("task_o", task_o, exp_m);
                    if (lat_chk) check("latency", cyc - e_m.acc_cyc, 2);
                    last_out = task_o;
                    n_out++;
                end
            end
            if (task_valid_i && task_ready_o) begin
                sb.push_back('{t: task_i, acc_cyc: cyc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_task(input logic [7:0] b);
        task_i.key          = $urandom;
        task_i.value        = $urandom;
        task_i.cmd          = ht_cmd_t'(2'($urandom));
        task_i.bucket       = b;
        task_i.head_ptr     = 10'($urandom);
        task_i.head_ptr_val = 1'($urandom);
        last_sent           = task_i;
        task_valid_i        = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        drive_task(b);
        @(negedge clk);
        while (!task_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", {127'd0, task_ready_o}, 128'd1);
        @(posedge clk);
        #1;
        task_valid_i = 1'b0;
    endtask

    task automatic write_head(input logic [7:0] b, input logic [9:0] p, input logic v);
        head_wr_en_i   = 1'b1;
        head_wr_addr_i = b;
        head_wr_data_i = '{ptr: p, ptr_val: v};
        step();
        head_wr_en_i   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || task_valid_o) && n < 100) begin
            step();
            n++;
        end
        check("drain_done", {127'd0, (sb.size() == 0) && !task_valid_o}, 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n0;
        int n;
        task_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", {127'd0, task_valid_o}, 128'd0);
        check("rst_ready_o", {127'd0, task_ready_o}, 128'd0);
        check("rst_init_done", {127'd0, init_done_o}, 128'd0);
        check("rst_task_o", task_o, 128'd0);

        // Clear sweep: 256 cycles not ready with a task waiting
        drive_task(8'h3A);
        rst_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (task_ready_o || init_done_o) bad++;
            step();
        end
        check("init_not_ready_cycles", bad, 0);
        check("init_done_257", {127'd0, init_done_o}, 128'd1);
        check("ready_257", {127'd0, task_ready_o}, 128'd1);
        step();
        task_valid_i = 1'b0;
        drain();
        check("first_lookup_ptr_val", {127'd0, last_out.head_ptr_val}, 128'd0);
        check("first_lookup_ptr", last_out.head_ptr, 128'd0);

        // Write then lookup two cycles later
        write_head(8'h3A, 10'h155, 1'b1);
        step();
        send(8'h3A);
        drain();
        check("wr_then_rd_ptr", last_out.head_ptr, 128'h155);
        check("wr_then_rd_val", {127'd0, last_out.head_ptr_val}, 128'd1);
        check("passthru_key", last_out.key, last_sent.key);
        check("passthru_value", last_out.value, last_sent.value);

        // Write in the same cycle as accept of the same bucket
        head_wr_en_i   = 1'b1;
        head_wr_addr_i = 8'h10;
        head_wr_data_i = '{ptr: 10'h0AB, ptr_val: 1'b1};
        check("fwd_ready", {127'd0, task_ready_o}, 128'd1);
        send(8'h10);
        head_wr_en_i = 1'b0;
        drain();
        check("fwd_accept_ptr", last_out.head_ptr, 128'h0AB);
        check("fwd_accept_val", {127'd0, last_out.head_ptr_val}, 128'd1);

        // Stall with 0x20 in S2 and 0x21 in S1, write 0x21 during stall
        lat_chk = 1'b0;
        task_ready_i = 1'b0;
        send(8'h20);
        send(8'h21);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                head_wr_en_i   = 1'b1;
                head_wr_addr_i = 8'h21;
                head_wr_data_i = '{ptr: 10'h3FF, ptr_val: 1'b1};
            end
            @(negedge clk);
            if (!task_valid_o || task_o.bucket != 8'h20 || task_ready_o) bad++;
            step();
            head_wr_en_i = 1'b0;
        end
        check("stall_hold", bad, 0);
        n0 = n_out;
        task_ready_i = 1'b1;
        drain();
        check("stall_out_count", n_out - n0, 2);
        check("stall_last_bucket", last_out.bucket, 128'h21);
        check("stall_last_ptr", last_out.head_ptr, 128'h3FF);
        lat_chk = 1'b1;

        // Back-to-back random stream with random writes to a few buckets
        n0 = n_out;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            drive_task(8'($urandom_range(0, 7)));
            head_wr_en_i           = 1'($urandom);
            head_wr_addr_i         = 8'($urandom_range(0, 7));
            head_wr_data_i.ptr     = 10'($urandom);
            head_wr_data_i.ptr_val = 1'($urandom);
            @(negedge clk);
            if (!task_ready_o) bad++;
            step();
        end
        task_valid_i = 1'b0;
        head_wr_en_i = 1'b0;
        check("stream_ready", bad, 0);
        drain();
        check("stream_out_count", n_out - n0, 100);

        // Reset with two tasks in flight
        send(8'h3A);
        send(8'h10);
        rst_i = 1'b1;
        #1;
        check("midrst_valid_o", {127'd0, task_valid_o}, 128'd0);
        check("midrst_ready_o", {127'd0, task_ready_o}, 128'd0);
        check("midrst_init_done", {127'd0, init_done_o}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        n = 0;
        while (!init_done_o && n < 1000) begin
            step();
            n++;
        end
        check("reinit_cycles", n, 256);
        send(8'h3A);
        drain();
        check("after_reinit_val", {127'd0, last_out.head_ptr_val}, 128'd0);
        check("after_reinit_ptr", last_out.head_ptr, 128'd0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/head_table_lookup.md
Name: head_table_lookup

Overview:
- Stage directly upstream of the data-table walker. Accepts hashed tasks (key/value/cmd/bucket) and reads the per-bucket head RAM.
- Emits a complete ht_data_task_t with head_ptr/head_ptr_val filled in.
- Owns the head RAM and takes head-pointer updates from the downstream data table, e.g. first insert into a bucket or deletion of a head entry.
- Sweep-clears the RAM after reset.

Parameters:
- BUCKET_WIDTH, default 8: bucket address width; head RAM holds 2**BUCKET_WIDTH entries.
- HEAD_PTR_WIDTH, default 10: width of the head pointer into the data table.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- task_i  in  $bits(ht_data_task_t)  input task; head_ptr/head_ptr_val fields ignored.
- task_valid_i  in  1  input valid.
- task_ready_o  out  1  input ready.
- task_o  out  $bits(ht_data_task_t)  task with head fields resolved.
- task_valid_o  out  1  output valid.
- task_ready_i  in  1  downstream ready.
- head_wr_en_i  in  1  head RAM write strobe from data table.
- head_wr_addr_i  in  BUCKET_WIDTH  bucket to update.
- head_wr_data_i  in  $bits(head_ram_data_t)  new {ptr, ptr_val}.
- init_done_o  out  1  head RAM clear complete.

Behaviour:
- Reset (async, active-high):
  - FSM goes to INIT and the clear counter goes to 0.
  - task_valid_o=0, task_ready_o=0, init_done_o=0, task_o=0.
  - Both pipeline valid flags clear.
- FSM INIT:
  - Each cycle writes {ptr=0, ptr_val=0} to address clr_cnt, then increments clr_cnt.
  - After writing address 2**BUCKET_WIDTH-1, moves to RUN. Clear takes exactly 2**BUCKET_WIDTH cycles.
  - head_wr_en_i is ignored in INIT.
- FSM RUN:
  - init_done_o=1.
  - The FSM stays in RUN until reset. Reset mid-operation drops all in-flight tasks and restarts INIT.
- Pipeline, two stages:
  - S1 holds the accepted task while the registered RAM read is in progress.
  - S2 is the output register.
  - advance = !s2_valid || task_ready_i.
  - task_ready_o = (state==RUN) && (!s1_valid || advance).
  - Minimum latency 2 cycles: a task accepted in cycle N appears on task_o in cycle N+2.
  - One task per cycle sustained throughput when task_ready_i=1.
- Stall:
  - S1 and S2 hold their contents.
  - The RAM read is not re-issued. S1 keeps its own captured head copy, loaded from RAM output on the cycle after the read.
- RAM read/write collision: the RAM returns old data. The block forwards as follows.
  - Write in the same cycle as accept, same bucket: S1 takes head_wr_data_i instead of RAM output.
  - Write with addr == S1.bucket while s1_valid: S1 head copy is updated.
  - Write with addr == S2.bucket while s2_valid and S2 is not leaving this cycle: task_o head fields are updated at the next edge.
- Net visibility rule:
  - task_o head fields reflect every write performed in cycles strictly before the current one.
  - A write in the same cycle as an output handshake is not reflected in that handshake; downstream accounts for it.
- Multiple in-flight tasks with the same bucket are all updated by a matching write.
- Only head fields are modified; key/value/cmd/bucket pass through unchanged.

Optional Feature:
- Macro: HEAD_TABLE_LOOKUP_STATS_EN.
- When defined, the block adds two 32-bit saturating counters, cleared on reset:
  - stat_lookups_o: counts output handshakes.
  - stat_empty_head_o: counts output handshakes with head_ptr_val=0.
  - Both are output ports.
- When undefined, the ports and counters are absent.

Decomposition:
- Package hash_table:
  - holds ht_data_task_t, head_ram_data_t, BUCKET_WIDTH, HEAD_PTR_WIDTH;
  - gains a new typedef head_ram_wr_t {addr, data, en} used by the data table and this block.
- One sub-module head_ram:
  - simple dual-port, 1 write / 1 read;
  - registered read, old data on same-address collision;
  - depth 2**BUCKET_WIDTH, width $bits(head_ram_data_t).

Test Plan:
- Reset, hold task_valid_i=1 → task_ready_o=0 for 256 cycles, init_done_o rises in cycle 257. First lookup of bucket 0x3A → head_ptr_val=0, head_ptr=0.
- Write bucket 0x3A={ptr=0x155, val=1}, then send task bucket 0x3A two cycles later → task_o valid 2 cycles after accept with head_ptr=0x155, head_ptr_val=1; key/value/cmd unchanged.
- Write bucket 0x10={0x0AB,1} in the same cycle as accept of bucket 0x10 task → output head_ptr=0x0AB (forwarded, not stale 0).
- task_ready_i=0 for 5 cycles with tasks for buckets 0x20 and 0x21 in S2/S1; write 0x21={0x3FF,1} during the stall → both held, no loss or duplication; on release outputs are 0x20 (old head), then 0x21 with ptr 0x3FF.
- Back-to-back stream of 100 tasks, random buckets and random writes, task_ready_i always 1 → 1 output per cycle. Every head matches a reference model applying writes before the output cycle.
- Assert rst_i with 2 tasks in flight → task_valid_o=0 immediately; INIT repeats; previously written heads read back as ptr_val=0.
